// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: round-robin merge of NUM_REQ valid/ready streams into one registered, id-tagged output (burst hold under ARB_BURST_EN)
module fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] din_i,
    input  logic [NUM_REQ-1:0]            din_v_i,
    output logic [NUM_REQ-1:0]            din_r_o,
    output logic [DATA_WIDTH-1:0]         dout_o,
    output logic                          dout_v_o,
    output logic [ID_WIDTH-1:0]           dout_id_o,
    input  logic                          dout_r_i
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 16 || ID_WIDTH < IW || MAX_BURST < 1) begin : g_bad_cfg
        $error("fifo_rr_arbiter: illegal parameter combination");
    end

    logic [1:0]            rst_sync_q;
    logic                  active;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_v_q, dout_v_d;
    logic [ID_WIDTH-1:0]   dout_id_q, dout_id_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         idx, gsel;
    logic                  any_v, load, xfer;
    logic [NUM_REQ-1:0]    grant;
`ifdef ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0]         burst_cnt_q, burst_cnt_d;
    logic                  hold_q, hold_d;
`endif

    // Two-flop release so leaving reset is seen synchronously; assertion still clears at once.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign active = rst_sync_q[1];

    // Pick the first valid requester at or after ptr, wrapping; a held burst owner overrides.
    always_comb begin
        any_v = 1'b0;
        gsel  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (!any_v && din_v_i[idx]) begin
                any_v = 1'b1;
                gsel  = idx;
            end
        end
`ifdef ARB_BURST_EN
        if (hold_q && din_v_i[dout_id_q[IW-1:0]]) begin
            any_v = 1'b1;
            gsel  = dout_id_q[IW-1:0];
        end
`endif
        grant = any_v ? (NUM_REQ'(1) << gsel) : '0;
    end

    assign load    = ~dout_v_q | dout_r_i;
    assign xfer    = any_v & load & active;
    assign din_r_o = grant & {NUM_REQ{load & active}};

    // Output slot: capture on transfer, empty when drained without a refill, hold when stalled.
    always_comb begin
        dout_d    = dout_q;
        dout_id_d = dout_id_q;
        dout_v_d  = dout_v_q & ~dout_r_i;
        ptr_d     = ptr_q;
        if (xfer) begin
            dout_d    = din_i[int'(gsel)*DATA_WIDTH +: DATA_WIDTH];
            dout_id_d = ID_WIDTH'(gsel);
            dout_v_d  = 1'b1;
            ptr_d     = (gsel == IW'(NUM_REQ - 1)) ? '0 : gsel + 1'b1;
        end
    end

    // Output and priority registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dout_q    <= '0;
            dout_v_q  <= 1'b0;
            dout_id_q <= '0;
            ptr_q     <= '0;
        end else begin
            dout_q    <= dout_d;
            dout_v_q  <= dout_v_d;
            dout_id_q <= dout_id_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef ARB_BURST_EN
    // Burst tracking: count consecutive grants to one owner, release at MAX_BURST or when it drops valid.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        hold_d      = hold_q;
        if (xfer) begin
            burst_cnt_d = (hold_q && gsel == dout_id_q[IW-1:0]) ? burst_cnt_q + 1'b1 : BW'(1);
            hold_d      = burst_cnt_d != BW'(MAX_BURST);
            if (!hold_d) burst_cnt_d = '0;
        end else if (hold_q && !din_v_i[dout_id_q[IW-1:0]]) begin
            hold_d      = 1'b0;
            burst_cnt_d = '0;
        end
    end

    // Burst state registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            burst_cnt_q <= '0;
            hold_q      <= 1'b0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            hold_q      <= hold_d;
        end
    end
`endif

    assign dout_o    = dout_q;
    assign dout_v_o  = dout_v_q;
    assign dout_id_o = dout_id_q;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed vector table plus hand sequences for reset, burst and reset release
module tb_fifo_rr_arbiter;
    localparam int DW = 32;
    localparam int N  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] din;
    logic [N-1:0]    din_v = '0;
    logic [N-1:0]    din_r;
    logic [DW-1:0]   dout;
    logic            dout_v;
    logic [1:0]      dout_id;
    logic            dout_r = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_rr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .ID_WIDTH(2), .MAX_BURST(4)) dut (
        .clock_i(clk), .reset_ni(rst_n), .din_i(din), .din_v_i(din_v), .din_r_o(din_r),
        .dout_o(dout), .dout_v_o(dout_v), .dout_id_o(dout_id), .dout_r_i(dout_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]  v;
        logic          rdy;
        logic [N-1:0]  e_r;
        logic          e_v;
        logic [DW-1:0] e_d;
        logic [1:0]    e_id;
    } vec_t;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        tick();
        chk("din_r after first edge", DW'(din_r), 0);
        tick();
        chk("din_r after second edge", DW'(din_r), DW'(din_v[0] ? 4'b0001 : 4'b0000));
    endtask

    initial begin
        vec_t tbl[19];
        for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'(32'hA0 + i);
        din_v = 4'b1111;
        dout_r = 1'b1;
        #1;
        chk("reset dout_v", DW'(dout_v), 0);
        chk("reset dout", dout, 0);
        chk("reset dout_id", DW'(dout_id), 0);
        chk("reset din_r", DW'(din_r), 0);
        tick();
        tick();
        release_reset();
`ifndef ARB_BURST_EN
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1};
        tbl[2]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 32'hA1, 2'd1};
        tbl[3]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 32'hA1, 2'd1};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 32'hA1, 2'd1};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 32'hA2, 2'd2};
        tbl[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3};
        tbl[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0};
        tbl[8]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'hA2, 2'd2};
        tbl[9]  = '{4'b0010, 1'b1, 4'b0010, 1'b1, 32'hA1, 2'd1};
        tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 32'hA0, 2'd0};
        tbl[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 32'hA0, 2'd0};
        tbl[13] = '{4'b0100, 1'b0, 4'b0100, 1'b1, 32'hA2, 2'd2};
        tbl[14] = '{4'b1100, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3};
        tbl[15] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 32'hA2, 2'd2};
        tbl[16] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 32'hA2, 2'd2};
        tbl[17] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 32'hA3, 2'd3};
        tbl[18] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 32'hA0, 2'd0};
        for (int i = 0; i < 19; i++) begin
            din_v  = tbl[i].v;
            dout_r = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d din_r", i), DW'(din_r), DW'(tbl[i].e_r));
            tick();
            chk($sformatf("vec%0d dout_v", i), DW'(dout_v), DW'(tbl[i].e_v));
            chk($sformatf("vec%0d dout", i), dout, tbl[i].e_d);
            chk($sformatf("vec%0d dout_id", i), DW'(dout_id), DW'(tbl[i].e_id));
        end
`else
        begin
            logic [1:0] exp_ids[11];
            exp_ids = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
            din_v  = 4'b0011;
            dout_r = 1'b1;
            for (int i = 0; i < 11; i++) begin
                if (i == 10) din_v = 4'b0010;
                tick();
                chk($sformatf("burst%0d dout_id", i), DW'(dout_id), DW'(exp_ids[i]));
                chk($sformatf("burst%0d dout", i), dout, DW'(32'hA0) + DW'(exp_ids[i]));
            end
        end
`endif
        din_v  = 4'b1111;
        dout_r = 1'b1;
        tick();
        chk("pre-reset dout_v", DW'(dout_v), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid reset dout_v", DW'(dout_v), 0);
        chk("mid reset dout", dout, 0);
        chk("mid reset dout_id", DW'(dout_id), 0);
        chk("mid reset din_r", DW'(din_r), 0);
        tick();
        release_reset();
        tick();
        chk("post reset dout", dout, 32'hA0);
        chk("post reset dout_id", DW'(dout_id), 0);
        chk("post reset dout_v", DW'(dout_v), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
